// File: rtl/seven_segment_monitor.sv
// Seven-segment receive monitor: synchronizes one digit's segment lines,
// filters transients and decodes each newly stable glyph to a hex nibble.
module seven_segment_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Segment_A,
   input  logic       i_Segment_B,
   input  logic       i_Segment_C,
   input  logic       i_Segment_D,
   input  logic       i_Segment_E,
   input  logic       i_Segment_F,
   input  logic       i_Segment_G,
   output logic [3:0] o_Nibble,
   output logic       o_Valid,
   output logic       o_Error,
   output logic       o_Blank,
   output logic [7:0] o_Change_Count
);

   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);

   typedef enum logic {SETTLING, STABLE} state_t;

   logic [6:0] seg_raw;
   logic [6:0] seg_lit;
   logic [6:0] sync1;
   logic [6:0] sync2;
   logic [6:0] r_Last;
   logic [6:0] r_Accepted;
   logic [7:0] r_Count;
   state_t     r_State;
   logic       glyph_ok;
   logic [3:0] glyph_val;

   assign seg_raw = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                     i_Segment_E, i_Segment_F, i_Segment_G};
   assign seg_lit = ACTIVE_LOW ? ~seg_raw : seg_raw;

   // Bit 6 is segment A, bit 0 is segment G; 1 = lit.
   always_comb begin
      glyph_ok  = 1'b1;
      glyph_val = 4'h0;
      unique case (sync2)
         7'h7E:   glyph_val = 4'h0;
         7'h30:   glyph_val = 4'h1;
         7'h6D:   glyph_val = 4'h2;
         7'h79:   glyph_val = 4'h3;
         7'h33:   glyph_val = 4'h4;
         7'h5B:   glyph_val = 4'h5;
         7'h5F:   glyph_val = 4'h6;
         7'h70:   glyph_val = 4'h7;
         7'h7F:   glyph_val = 4'h8;
         7'h7B:   glyph_val = 4'h9;
         7'h77:   glyph_val = 4'hA;
         7'h1F:   glyph_val = 4'hB;
         7'h4E:   glyph_val = 4'hC;
         7'h3D:   glyph_val = 4'hD;
         7'h4F:   glyph_val = 4'hE;
         7'h47:   glyph_val = 4'hF;
         default: glyph_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sync1          <= '0;
         sync2          <= '0;
         r_Last         <= '0;
         r_Accepted     <= '0;
         r_Count        <= '0;
         r_State        <= STABLE;
         o_Nibble       <= '0;
         o_Valid        <= 1'b0;
         o_Error        <= 1'b0;
         o_Blank        <= 1'b1;
         o_Change_Count <= '0;
      end else begin
         sync1   <= seg_lit;
         sync2   <= sync1;
         r_Last  <= sync2;
         o_Valid <= 1'b0;
         o_Error <= 1'b0;
         if (sync2 != r_Last) begin
            r_Count <= '0;
            r_State <= SETTLING;
         end else if (r_State == SETTLING) begin
            r_Count <= r_Count + 8'd1;
            if (r_Count + 8'd1 == STABLE_LAST) begin
               r_State <= STABLE;
               // A glitch that settles back to the prior pattern is silent.
               if (sync2 != r_Accepted) begin
                  r_Accepted <= sync2;
                  if (sync2 == '0) begin
                     o_Blank <= 1'b1;
                  end else if (glyph_ok) begin
                     o_Nibble <= glyph_val;
                     o_Valid  <= 1'b1;
                     o_Blank  <= 1'b0;
                     if (o_Change_Count != 8'hFF)
                        o_Change_Count <= o_Change_Count + 8'd1;
                  end else begin
                     o_Error <= 1'b1;
                     o_Blank <= 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule
